mock_bus_memory: RTL and testbench

MOCK_BUS_MEMORY -- requirements
Module: mock_bus_memory

---
 rtl/mock_bus_memory_pkg.sv | 26 ++
 rtl/mock_bus_memory_if.sv | 33 +++
 rtl/mock_bus_memory_trace_fifo.sv | 69 ++++++
 rtl/mock_bus_memory.sv | 118 +++++++++++
 tb/tb_mock_bus_memory.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mock_bus_memory_pkg.sv
// Shared types for the mock bus memory: access FSM states, trace entry layout
// and the wait-state limit.
package mock_bus_memory_pkg;

  localparam int WAIT_STATES_MAX = 15;
  localparam int TRACE_ADDR_MAX  = 32;
  localparam int TRACE_DATA_MAX  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } acc_state_t;

  // Widest supported entry; the top narrows it to its own address/data widths.
  typedef struct packed {
    logic                      write;
    logic [TRACE_ADDR_MAX-1:0] addr;
    logic [TRACE_DATA_MAX-1:0] data;
  } trace_entry_t;

  function automatic logic [3:0] wait_load(input int ws);
    return (ws > 0) ? 4'(ws - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/mock_bus_memory_if.sv
// CPU bus, preload port and trace read-out of the mock bus memory.
interface mock_bus_memory_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int TRACE_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  trace_pop;
  logic                  trace_valid;
  logic [TRACE_W-1:0]    trace_entry;
  logic                  trace_overflow;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, load_en, load_addr, load_data, trace_pop,
    input  req_ready, rsp_valid, rsp_rdata, trace_valid, trace_entry, trace_overflow
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, load_en, load_addr, load_data, trace_pop,
    output req_ready, rsp_valid, rsp_rdata, trace_valid, trace_entry, trace_overflow
  );

endinterface

// File: rtl/mock_bus_memory_trace_fifo.sv
// Occupancy-counted FIFO holding completed-access trace entries; drops pushes
// when full and records that in a sticky overflow flag.
module trace_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic             o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_COUNT);
  assign w_do_pop  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !w_do_push) begin
        r_overflow <= 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_valid    = !w_empty;
  assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/mock_bus_memory.sv
// Behavioural CPU-bus memory with programmable wait states, a bench preload
// port and a trace FIFO recording every completed access.
module mock_bus_memory
  import mock_bus_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 65536,
  parameter int WAIT_STATES = 0,
  parameter int TRACE_DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  mock_bus_memory_if.slave  bus
);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         TW        = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_STATES);

  acc_state_t            r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_load_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_accept;
  logic                  w_resp;
  logic                  w_commit;
  logic                  w_load;
  trace_entry_t          w_trace;
  logic [TW-1:0]         w_push_data;
  logic                  w_unused_trace;
  logic                  w_unused_load;

  assign w_idx      = r_addr[IDX_W-1:0];
  assign w_load_idx = bus.load_addr[IDX_W-1:0];
  assign w_rd_word  = r_mem[w_idx];
  assign w_accept   = bus.req_valid && (r_state == ST_IDLE);
  assign w_resp     = (r_state == ST_RESP);
  assign w_commit   = w_resp && r_write && !reset;
  assign w_load     = bus.load_en && !reset;

  // Access FSM: accept in IDLE, count wait states, one-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= WAIT_LOAD;
            r_state <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage survives reset; the bus write is ordered last so it beats a same-index load.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[w_load_idx] <= bus.load_data;
    end
    if (w_commit) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  always_comb begin
    w_trace       = '0;
    w_trace.write = r_write;
    w_trace.addr  = TRACE_ADDR_MAX'(r_addr);
    w_trace.data  = r_write ? TRACE_DATA_MAX'(r_wdata) : TRACE_DATA_MAX'(w_rd_word);
  end

  assign w_push_data    = {w_trace.write, w_trace.addr[ADDR_WIDTH-1:0], w_trace.data[DATA_WIDTH-1:0]};
  assign w_unused_trace = ^w_trace;
  assign w_unused_load  = ^bus.load_addr;

  trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_resp),
    .i_push_data (w_push_data),
    .i_pop       (bus.trace_pop),
    .o_valid     (bus.trace_valid),
    .o_head      (bus.trace_entry),
    .o_overflow  (bus.trace_overflow)
  );

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = w_resp;
  assign bus.rsp_rdata = (w_resp && !r_write) ? w_rd_word : '0;

endmodule

// File: tb/tb_mock_bus_memory.sv
// Randomized self-checking bench for mock_bus_memory against a queue/array model.
module tb_mock_bus_memory;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int WS = 3;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  logic [7:0]  mem_m [256];
  logic [24:0] tq [$];
  bit          ovf_m;

  always #5 clk = ~clk;

  mock_bus_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  mock_bus_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  mock_bus_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(65536), .WAIT_STATES(0), .TRACE_DEPTH(16))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mock_bus_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256), .WAIT_STATES(WS), .TRACE_DEPTH(TD))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tq.delete();
    ovf_m = 1'b0;
  endtask

  // One access on dut1; optional trace pop / preload driven during the response cycle.
  task automatic access(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                        input bit pop_r, input bit ld_r, input logic [15:0] la, input logic [7:0] ld);
    int n;
    bit done;
    logic [7:0] exp_rd;
    logic [7:0] dval;
    bus1.req_valid = 1'b1;
    bus1.req_write = wr;
    bus1.req_addr  = addr;
    bus1.req_wdata = wd;
    @(negedge clk);
    total++;
    if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL accept_ready got=%b want=1", bus1.req_ready); end
    @(posedge clk);
    #1;
    bus1.req_write = 1'($urandom);
    bus1.req_addr  = 16'($urandom);
    bus1.req_wdata = 8'($urandom);
    n = 1;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus1.rsp_valid === 1'b1) begin
        done = 1'b1;
      end else begin
        total++;
        if (bus1.req_ready !== 1'b0) begin bad++; $display("FAIL busy_ready cyc=%0d got=%b want=0", n, bus1.req_ready); end
        if (n >= 20) begin
          total++; bad++;
          $display("FAIL rsp_timeout got=none want=rsp_valid");
          bus1.req_valid = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
        n++;
      end
    end
    bus1.req_valid = 1'b0;
    exp_rd = wr ? 8'h00 : mem_m[addr[7:0]];
    dval   = wr ? wd : mem_m[addr[7:0]];
    total++;
    if (n != WS + 1) begin bad++; $display("FAIL latency got=%0d want=%0d", n, WS + 1); end
    total++;
    if (bus1.req_ready !== 1'b0) begin bad++; $display("FAIL resp_ready got=%b want=0", bus1.req_ready); end
    total++;
    if (bus1.rsp_rdata !== exp_rd) begin bad++; $display("FAIL rdata addr=%h got=%h want=%h", addr, bus1.rsp_rdata, exp_rd); end
    if (pop_r) bus1.trace_pop = 1'b1;
    if (ld_r) begin
      bus1.load_en   = 1'b1;
      bus1.load_addr = la;
      bus1.load_data = ld;
    end
    @(posedge clk);
    #1;
    bus1.trace_pop = 1'b0;
    bus1.load_en   = 1'b0;
    if (pop_r && tq.size() > 0) void'(tq.pop_front());
    if (ld_r) mem_m[la[7:0]] = ld;
    if (wr) mem_m[addr[7:0]] = wd;
    if (tq.size() < TD) tq.push_back({wr, addr, dval});
    else ovf_m = 1'b1;
  endtask

  task automatic pop_check();
    @(negedge clk);
    total++;
    if (bus1.trace_valid !== (tq.size() != 0)) begin
      bad++; $display("FAIL trace_valid got=%b want=%b", bus1.trace_valid, tq.size() != 0);
    end
    if (tq.size() > 0) begin
      total++;
      if (bus1.trace_entry !== tq[0]) begin bad++; $display("FAIL trace_entry got=%h want=%h", bus1.trace_entry, tq[0]); end
    end
    bus1.trace_pop = 1'b1;
    @(posedge clk);
    #1;
    bus1.trace_pop = 1'b0;
    if (tq.size() > 0) void'(tq.pop_front());
  endtask

  task automatic check_ovf(input string tag);
    @(negedge clk);
    total++;
    if (bus1.trace_overflow !== ovf_m) begin bad++; $display("FAIL %s got=%b want=%b", tag, bus1.trace_overflow, ovf_m); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus1.req_ready); end
    total++; if (bus1.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus1.rsp_valid); end
    total++; if (bus1.rsp_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", bus1.rsp_rdata); end
    total++; if (bus1.trace_valid !== 1'b0) begin bad++; $display("FAIL rst_trace_valid got=%b want=0", bus1.trace_valid); end
    total++; if (bus1.trace_entry !== 25'h0) begin bad++; $display("FAIL rst_trace_entry got=%h want=0", bus1.trace_entry); end
    total++; if (bus1.trace_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", bus1.trace_overflow); end
    total++; if (bus0.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready0 got=%b want=1", bus0.req_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_preload();
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      bus1.load_en   = 1'b1;
      bus1.load_addr = {8'($urandom), 8'(i)};
      bus1.load_data = d;
      mem_m[i] = d;
      @(posedge clk);
      #1;
    end
    bus1.load_en = 1'b0;
  endtask

  task automatic test_zero_wait();
    bus0.load_en = 1'b1; bus0.load_addr = 16'h1234; bus0.load_data = 8'hAB;
    @(posedge clk); #1;
    bus0.load_en = 1'b0;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 16'h1234; bus0.req_wdata = 8'h00;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    total++; if (bus0.rsp_valid !== 1'b1) begin bad++; $display("FAIL zw_rsp_valid got=%b want=1", bus0.rsp_valid); end
    total++; if (bus0.rsp_rdata !== 8'hAB) begin bad++; $display("FAIL zw_rdata got=%h want=ab", bus0.rsp_rdata); end
    total++; if (bus0.req_ready !== 1'b0) begin bad++; $display("FAIL zw_ready got=%b want=0", bus0.req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus0.rsp_valid !== 1'b0) begin bad++; $display("FAIL zw_rsp_pulse got=%b want=0", bus0.rsp_valid); end
    total++; if (bus0.trace_entry !== {1'b0, 16'h1234, 8'hAB}) begin
      bad++; $display("FAIL zw_trace got=%h want=%h", bus0.trace_entry, {1'b0, 16'h1234, 8'hAB});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states();
    access(1'b1, 16'hC000, 8'h55, 1'b0, 1'b0, 16'h0, 8'h0);
    access(1'b0, 16'hC000, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
    total++; if (mem_m[8'h00] !== 8'h55) begin bad++; $display("FAIL ws_model got=%h want=55", mem_m[8'h00]); end
  endtask

  task automatic test_wrap();
    access(1'b1, 16'h01FF, 8'h77, 1'b0, 1'b0, 16'h0, 8'h0);
    access(1'b0, 16'h00FF, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_trace();
    do_reset();
    for (int i = 0; i < 4; i++) access(1'($urandom), 16'($urandom), 8'($urandom), 1'b0, 1'b0, 16'h0, 8'h0);
    check_ovf("ovf_after_fill");
    access(1'b0, 16'($urandom), 8'h00, 1'b1, 1'b0, 16'h0, 8'h0);
    check_ovf("ovf_push_pop_full");
    access(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b0, 16'h0, 8'h0);
    check_ovf("ovf_dropped");
    for (int i = 0; i < 5; i++) pop_check();
    access(1'b1, 16'($urandom), 8'($urandom), 1'b0, 1'b0, 16'h0, 8'h0);
    pop_check();
    pop_check();
  endtask

  task automatic test_reset_abort();
    bit seen;
    do_reset();
    bus1.load_en = 1'b1; bus1.load_addr = 16'h0010; bus1.load_data = 8'h11;
    mem_m[8'h10] = 8'h11;
    @(posedge clk); #1;
    bus1.load_en = 1'b0;
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 16'h0010; bus1.req_wdata = 8'h99;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", bus1.req_ready); end
    total++; if (bus1.trace_valid !== 1'b0) begin bad++; $display("FAIL abort_trace got=%b want=0", bus1.trace_valid); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus1.rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++; if (seen) begin bad++; $display("FAIL abort_rsp got=pulse want=none"); end
    @(posedge clk); #1;
    access(1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
    pop_check();
  endtask

  task automatic test_collision();
    access(1'b1, 16'h0040, 8'h33, 1'b0, 1'b1, 16'h0040, 8'h22);
    access(1'b0, 16'h0040, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
    access(1'b1, 16'h0041, 8'h44, 1'b0, 1'b1, 16'h0150, 8'h66);
    access(1'b0, 16'h0050, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
    access(1'b0, 16'h0041, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      access(1'($urandom), 16'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), 16'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) pop_check();
    end
    check_ovf("ovf_random");
    for (int i = 0; i < TD + 1; i++) pop_check();
  endtask

  initial begin
    reset = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.load_en = 1'b0; bus0.load_addr = '0; bus0.load_data = '0; bus0.trace_pop = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.load_en = 1'b0; bus1.load_addr = '0; bus1.load_data = '0; bus1.trace_pop = 1'b0;
    test_reset();
    test_preload();
    test_zero_wait();
    test_wait_states();
    test_wrap();
    test_trace();
    test_reset_abort();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
